mips_store_checker: RTL and testbench
=====================================

// Module: mips_store_checker
// PURPOSE
//  Synthesizable pass/fail monitor that sits directly downstream of MultiCycleMipsTop.
//  Watches the CPU data-memory write bus (memwrite/dataadr/writedata) and issues a verdict:
//  - PASS: the expected value is written to the expected address.
//  - FAIL: any other outcome.
//  Also keeps cycle and store counters and a small circular log of recent stores.
//  Lets the self-check run on FPGA with verdict on LEDs/debug, not only in simulation.
// PARAMETERS
//  EXPECT_ADDR    32'd80  address whose store ends the test
//  EXPECT_DATA    32'd7   data required at EXPECT_ADDR for PASS
//  STRICT_ADDR    1       1: store to any other address = FAIL; 0: such stores logged/ignored
//  TIMEOUT_CYCLES 1000    RUN cycles allowed before TIMEOUT verdict (>=2)
//  LOG_DEPTH      4       entries in store log (power of 2, >=2)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high
//  memwrite   in   1      CPU data-memory write strobe
//  dataadr    in   32     CPU data-memory address
//  writedata  in   32     CPU data-memory write data
//  log_idx    in   $clog2(LOG_DEPTH)  log read index, 0 = most recent store
//  done       out  1      verdict reached (sticky)
//  pass       out  1      verdict is PASS (valid when done)
//  fail_code  out  2      00 none/pass, 01 wrong data, 10 wrong address, 11 timeout
//  cycle_count out 32     cycles spent in RUN
//  store_count out 16     stores seen in RUN, saturating at 16'hFFFF
//  log_valid  out  1      entry at log_idx holds a real store
//  log_addr   out  32     address of log entry log_idx
//  log_data   out  32     data of log entry log_idx
// BEHAVIOUR
//  Reset (async): state=IDLE; done=0, pass=0, fail_code=00, cycle_count=0, store_count=0,
//   all log entries invalid, write pointer=0; log_addr/log_data read 0 when invalid.
//  FSM: IDLE -> RUN on first rising edge after reset deasserts (unconditional).
//   RUN -> PASS / FAIL / TIMEOUT; terminal states sticky until reset.
//  Sampling: bus sampled on rising clk; each cycle with memwrite=1 in RUN = one store
//   (multicycle CPU holds memwrite for one cycle per sw).
//  Per store in RUN (registered, verdict visible the cycle after the store edge):
//   - dataadr==EXPECT_ADDR & writedata==EXPECT_DATA -> PASS, pass=1, fail_code=00
//   - dataadr==EXPECT_ADDR & data mismatch -> FAIL, fail_code=01
//   - dataadr!=EXPECT_ADDR & STRICT_ADDR=1 -> FAIL, fail_code=10
//   - dataadr!=EXPECT_ADDR & STRICT_ADDR=0 -> remain RUN
//   - every RUN store (incl. the verdict store) is logged and increments store_count
//  done=1 in PASS, FAIL, TIMEOUT; done and fail_code change together.
//  cycle_count: +1 every RUN cycle. Timeout when cycle_count==TIMEOUT_CYCLES-1 and no store
//   verdict that cycle -> TIMEOUT, fail_code=11. A store verdict in the same cycle wins.
//  After done: counters frozen, log frozen, memwrite ignored.
//  Log: circular; write pointer wraps modulo LOG_DEPTH; oldest entry overwritten when full.
//   log_idx=k reads entry (wptr-1-k) mod LOG_DEPTH, combinationally.
//   log_valid=0 when k >= number of stores logged.
//  Stores seen in IDLE: ignored (not logged, not counted).
//  reset mid-RUN or in a terminal state: immediate async return to reset values.
//  X on bus with memwrite=0: no effect.
// TESTING
//  1 reset 22ns, sw 7->addr 84 then sw 7->addr 80 (STRICT_ADDR=0) -> done=1, pass=1,
//    fail_code=00, store_count=2, log_idx0=(80,7), log_idx1=(84,7).
//  2 STRICT_ADDR=1, first store addr 84 -> cycle after: done=1, fail_code=10, pass=0.
//  3 store (80,5) -> fail_code=01; later store (80,7) -> verdict unchanged, store_count=1.
//  4 TIMEOUT_CYCLES=20, no stores -> done=1, fail_code=11, cycle_count=19;
//    also store (80,7) exactly at cycle 19 -> PASS wins.
//  5 LOG_DEPTH=4, STRICT_ADDR=0, 6 stores to addrs 0,4..20 -> log_idx0..3 = 20,16,12,8,
//    all valid; after 1 store only, log_idx1 log_valid=0.
//  6 assert reset mid-RUN and after PASS -> all outputs return to reset values without
//    a clock edge; IDLE->RUN resumes on next edge.

Source files
------------

// File: rtl/mips_store_checker.sv
// Pass/fail monitor for the multicycle MIPS data-memory write bus: watches stores,
// issues a sticky verdict, and keeps cycle/store counters plus a circular store log.
module mips_store_checker #(
    parameter logic [31:0] EXPECT_ADDR    = 32'd80,
    parameter logic [31:0] EXPECT_DATA    = 32'd7,
    parameter bit          STRICT_ADDR    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned LOG_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memwrite,
    input  logic [31:0]                  dataadr,
    input  logic [31:0]                  writedata,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   fail_code,
    output logic [31:0]                  cycle_count,
    output logic [15:0]                  store_count,
    output logic                         log_valid,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data
);

    localparam int PW = $clog2(LOG_DEPTH);
    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [PW:0] FULL       = (PW+1)'(LOG_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [1:0]    fc_q, fc_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [15:0]   sc_q, sc_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW:0]   num_q, num_d;
    logic          log_we;

    logic [31:0]   addr_mem [LOG_DEPTH];
    logic [31:0]   data_mem [LOG_DEPTH];
    logic [PW-1:0] rd_idx;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fc_d    = fc_q;
        cyc_d   = cyc_q;
        sc_d    = sc_q;
        wptr_d  = wptr_q;
        num_d   = num_q;
        log_we  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (memwrite) begin
                    log_we = 1'b1;
                    wptr_d = wptr_q + PW'(1);
                    if (num_q != FULL) num_d = num_q + (PW+1)'(1);
                    sc_d = sat_inc16(sc_q);
                    if (dataadr == EXPECT_ADDR) begin
                        done_d = 1'b1;
                        if (writedata == EXPECT_DATA) begin
                            state_d = S_PASS;
                            pass_d  = 1'b1;
                            fc_d    = 2'b00;
                        end else begin
                            state_d = S_FAIL;
                            fc_d    = 2'b01;
                        end
                    end else if (STRICT_ADDR) begin
                        state_d = S_FAIL;
                        done_d  = 1'b1;
                        fc_d    = 2'b10;
                    end
                end
                // A store verdict takes priority over the timeout on the same cycle.
                if (state_d == S_RUN) begin
                    if (cyc_q == LAST_CYCLE) begin
                        state_d = S_TIMEOUT;
                        done_d  = 1'b1;
                        fc_d    = 2'b11;
                    end else begin
                        cyc_d = cyc_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= 2'b00;
            cyc_q   <= 32'd0;
            sc_q    <= 16'd0;
            wptr_q  <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            cyc_q   <= cyc_d;
            sc_q    <= sc_d;
            wptr_q  <= wptr_d;
            num_q   <= num_d;
        end
    end

    // Log payload needs no reset: invalid entries are masked to zero on read.
    always_ff @(posedge clk) begin
        if (log_we) begin
            addr_mem[wptr_q] <= dataadr;
            data_mem[wptr_q] <= writedata;
        end
    end

    assign rd_idx      = wptr_q - PW'(1) - log_idx;
    assign log_valid   = ({1'b0, log_idx} < num_q);
    assign log_addr    = log_valid ? addr_mem[rd_idx] : 32'd0;
    assign log_data    = log_valid ? data_mem[rd_idx] : 32'd0;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fc_q;
    assign cycle_count = cyc_q;
    assign store_count = sc_q;

endmodule

// File: tb/tb_mips_store_checker.sv
// Directed bench for mips_store_checker: a lenient-address and a strict-address instance
// share one bus; single-store verdicts are table driven, multi-cycle cases hand written.
module tb_mips_store_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [1:0]  log_idx;

    logic        a_done, a_pass, a_lv;
    logic [1:0]  a_fc;
    logic [31:0] a_cc, a_la, a_ld;
    logic [15:0] a_sc;
    logic        b_done, b_pass, b_lv;
    logic [1:0]  b_fc;
    logic [31:0] b_cc, b_la, b_ld;
    logic [15:0] b_sc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_store_checker #(.STRICT_ADDR(1'b0), .TIMEOUT_CYCLES(20), .LOG_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .log_idx(log_idx), .done(a_done), .pass(a_pass),
        .fail_code(a_fc), .cycle_count(a_cc), .store_count(a_sc), .log_valid(a_lv),
        .log_addr(a_la), .log_data(a_ld));

    mips_store_checker #(.STRICT_ADDR(1'b1), .TIMEOUT_CYCLES(20), .LOG_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .log_idx(log_idx), .done(b_done), .pass(b_pass),
        .fail_code(b_fc), .cycle_count(b_cc), .store_count(b_sc), .log_valid(b_lv),
        .log_addr(b_la), .log_data(b_ld));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        a_done;
        logic        a_pass;
        logic [1:0]  a_fc;
        logic        b_done;
        logic        b_pass;
        logic [1:0]  b_fc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_done"}, {31'd0, a_done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, a_pass}, 32'd0);
        chk({tag, "_fc"}, {30'd0, a_fc}, 32'd0);
        chk({tag, "_cc"}, a_cc, 32'd0);
        chk({tag, "_sc"}, {16'd0, a_sc}, 32'd0);
        chk({tag, "_lv"}, {31'd0, a_lv}, 32'd0);
        chk({tag, "_la"}, a_la, 32'd0);
        chk({tag, "_ld"}, a_ld, 32'd0);
        chk({tag, "_b_done"}, {31'd0, b_done}, 32'd0);
    endtask

    // Reset, release at a falling edge; the next rising edge moves IDLE->RUN.
    task automatic do_reset();
        @(negedge clk);
        memwrite = 1'b0;
        log_idx  = 2'd0;
        reset    = 1'b1;
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
        dataadr   = 32'hx;
        writedata = 32'hx;
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'hx;
        writedata = 32'hx;
        log_idx   = 2'd0;
        #22;

        vecs[0] = '{32'd80, 32'd7,          1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 2'b00};
        vecs[1] = '{32'd80, 32'd5,          1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b01};
        vecs[2] = '{32'd84, 32'd7,          1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10};
        vecs[3] = '{32'd0,  32'd0,          1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10};
        vecs[4] = '{32'd80, 32'hFFFF_FFFF,  1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b01};
        vecs[5] = '{32'd81, 32'd7,          1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10};

        // Single store on the first RUN cycle; verdict visible one cycle later.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            @(negedge clk);
            store(vecs[i].addr, vecs[i].data);
            chk($sformatf("v%0d_a_done", i), {31'd0, a_done}, {31'd0, vecs[i].a_done});
            chk($sformatf("v%0d_a_pass", i), {31'd0, a_pass}, {31'd0, vecs[i].a_pass});
            chk($sformatf("v%0d_a_fc", i), {30'd0, a_fc}, {30'd0, vecs[i].a_fc});
            chk($sformatf("v%0d_b_done", i), {31'd0, b_done}, {31'd0, vecs[i].b_done});
            chk($sformatf("v%0d_b_pass", i), {31'd0, b_pass}, {31'd0, vecs[i].b_pass});
            chk($sformatf("v%0d_b_fc", i), {30'd0, b_fc}, {30'd0, vecs[i].b_fc});
            chk($sformatf("v%0d_b_sc", i), {16'd0, b_sc}, 32'd1);
            chk($sformatf("v%0d_b_cc", i), b_cc, 32'd0);
            chk($sformatf("v%0d_b_log", i), b_la, vecs[i].addr);
        end

        // Store during IDLE is ignored; then 84 then 80 on the lenient instance passes.
        do_reset();
        memwrite  = 1'b1;
        dataadr   = 32'd80;
        writedata = 32'd7;
        @(negedge clk);
        memwrite = 1'b0;
        chk("idle_done", {31'd0, a_done}, 32'd0);
        chk("idle_sc", {16'd0, a_sc}, 32'd0);
        chk("idle_lv", {31'd0, a_lv}, 32'd0);
        store(32'd84, 32'd7);
        chk("t1_mid_done", {31'd0, a_done}, 32'd0);
        store(32'd80, 32'd7);
        chk("t1_done", {31'd0, a_done}, 32'd1);
        chk("t1_pass", {31'd0, a_pass}, 32'd1);
        chk("t1_fc", {30'd0, a_fc}, 32'd0);
        chk("t1_sc", {16'd0, a_sc}, 32'd2);
        log_idx = 2'd0; #1;
        chk("t1_l0_addr", a_la, 32'd80);
        chk("t1_l0_data", a_ld, 32'd7);
        log_idx = 2'd1; #1;
        chk("t1_l1_addr", a_la, 32'd84);
        chk("t1_l1_data", a_ld, 32'd7);
        log_idx = 2'd2; #1;
        chk("t1_l2_valid", {31'd0, a_lv}, 32'd0);
        chk("t1_l2_addr", a_la, 32'd0);

        // Asynchronous reset after PASS, away from any clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_pass_done", {31'd0, a_done}, 32'd0);
        chk("rst_pass_pass", {31'd0, a_pass}, 32'd0);
        chk("rst_pass_sc", {16'd0, a_sc}, 32'd0);
        chk("rst_pass_lv", {31'd0, a_lv}, 32'd0);

        // Wrong data is sticky; a later correct store is ignored and counters freeze.
        do_reset();
        @(negedge clk);
        store(32'd80, 32'd5);
        store(32'd80, 32'd7);
        repeat (4) @(negedge clk);
        chk("t3_fc", {30'd0, a_fc}, 32'd1);
        chk("t3_pass", {31'd0, a_pass}, 32'd0);
        chk("t3_sc", {16'd0, a_sc}, 32'd1);
        chk("t3_cc", a_cc, 32'd0);
        log_idx = 2'd0; #1;
        chk("t3_log", a_ld, 32'd5);

        // Timeout with no stores: cycle_count stops at TIMEOUT_CYCLES-1.
        do_reset();
        repeat (20) @(negedge clk);
        chk("t4_pre_done", {31'd0, a_done}, 32'd0);
        chk("t4_pre_cc", a_cc, 32'd19);
        @(negedge clk);
        chk("t4_done", {31'd0, a_done}, 32'd1);
        chk("t4_fc", {30'd0, a_fc}, 32'd3);
        chk("t4_pass", {31'd0, a_pass}, 32'd0);
        chk("t4_cc", a_cc, 32'd19);
        repeat (3) @(negedge clk);
        chk("t4_cc_frozen", a_cc, 32'd19);

        // Correct store on the final RUN cycle beats the timeout.
        do_reset();
        repeat (20) @(negedge clk);
        store(32'd80, 32'd7);
        chk("t4b_done", {31'd0, a_done}, 32'd1);
        chk("t4b_pass", {31'd0, a_pass}, 32'd1);
        chk("t4b_fc", {30'd0, a_fc}, 32'd0);
        chk("t4b_b_fc", {30'd0, b_fc}, 32'd0);

        // Log wrap: six stores into a four-entry log.
        do_reset();
        @(negedge clk);
        store(32'd0, 32'd100);
        log_idx = 2'd0; #1;
        chk("t5_one_l0_valid", {31'd0, a_lv}, 32'd1);
        chk("t5_one_l0_addr", a_la, 32'd0);
        log_idx = 2'd1; #1;
        chk("t5_one_l1_valid", {31'd0, a_lv}, 32'd0);
        chk("t5_one_l1_addr", a_la, 32'd0);
        @(negedge clk);
        for (int i = 1; i < 6; i++) store(32'(4 * i), 32'(100 + i));
        chk("t5_sc", {16'd0, a_sc}, 32'd6);
        chk("t5_done", {31'd0, a_done}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            log_idx = 2'(k); #1;
            chk($sformatf("t5_l%0d_valid", k), {31'd0, a_lv}, 32'd1);
            chk($sformatf("t5_l%0d_addr", k), a_la, 32'(20 - 4 * k));
            chk($sformatf("t5_l%0d_data", k), a_ld, 32'(105 - k));
        end

        // Reset mid-RUN without a clock edge, then RUN resumes after release.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_sc", {16'd0, a_sc}, 32'd0);
        chk("t6_cc", a_cc, 32'd0);
        chk("t6_lv", {31'd0, a_lv}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        store(32'd80, 32'd7);
        chk("t6_resume_pass", {31'd0, a_pass}, 32'd1);
        chk("t6_resume_sc", {16'd0, a_sc}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
